data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 104 ++++++++++
 tb/tb_data_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave: accepts one load/store at a time, waits a
// fixed number of cycles, then returns a single-cycle response strobe.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state, state_next;
  logic [3:0]        count, count_next;
  logic              write_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              addr_err;
  logic              accept;
  logic              do_access;

  assign req_ready = (state == IDLE) && enable;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign do_access = (state == RESP);
  assign idx       = addr_q[ADDR_W+1:2];
  assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);

  always_comb begin
    state_next = state;
    count_next = count;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            count_next = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (count == 4'd0) state_next = RESP;
        else               count_next = count - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      resp_valid <= do_access;
      if (do_access) resp_error <= addr_err;
    end
  end

  // Request fields are captured once so later input activity cannot disturb the access.
  always_ff @(posedge clock) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)         resp_rdata <= '0;
    else if (do_access) resp_rdata <= (addr_err || write_q) ? '0 : mem[idx];
  end

  // Memory is never cleared; a reset before the access cycle drops the store.
  always_ff @(posedge clock) begin
    if (reset && do_access && write_q && !addr_err) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a transaction-level model,
// with directed cases pinning latency, errors, reset abort and enable gating.
module tb_data_mem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error, busy;
  logic [31:0] resp_rdata;

  logic        en0 = 1'b0, v0 = 1'b0, w0 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0;
  logic        rdy0, rv0, re0, busy0;
  logic [31:0] rd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .ADDR_W(6), .WAIT_CYCLES(W)) dut (
    .clock(clk), .reset(rst_n), .enable(enable), .req_valid(req_valid),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .busy(busy)
  );

  data_mem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_CYCLES(0)) dut0 (
    .clock(clk), .reset(rst_n), .enable(en0), .req_valid(v0),
    .req_write(w0), .req_addr(a0), .req_wdata(d0),
    .req_ready(rdy0), .resp_valid(rv0), .resp_rdata(rd0),
    .resp_error(re0), .busy(busy0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding request, response W+1 edges after accept.
  logic [31:0] mmem [DEPTH];
  int          edge_n = 0;
  int          m_acc = 0;
  logic        m_live = 1'b0, m_active = 1'b0, m_valid = 1'b0, m_err = 1'b0, m_wr = 1'b0;
  logic [31:0] m_rdata = '0, m_addr = '0, m_wd = '0;

  function automatic logic txn_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * DEPTH);
  endfunction

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!rst_n) begin
      m_live   <= 1'b1;
      m_active <= 1'b0;
      m_valid  <= 1'b0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
    end else begin
      m_valid <= 1'b0;
      if (m_active && edge_n == m_acc + W + 1) begin
        m_active <= 1'b0;
        m_valid  <= 1'b1;
        m_err    <= txn_err(m_addr);
        m_rdata  <= (txn_err(m_addr) || m_wr) ? 32'h0 : mmem[m_addr[7:2]];
        if (!txn_err(m_addr) && m_wr) mmem[m_addr[7:2]] <= m_wd;
      end else if (!m_active && enable && req_valid) begin
        m_active <= 1'b1;
        m_acc    <= edge_n;
        m_wr     <= req_write;
        m_addr   <= req_addr;
        m_wd     <= req_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("ready", req_ready, !m_active && enable);
      check("busy", busy, m_active);
      check("resp_valid", resp_valid, m_valid);
      if (m_valid) begin
        check("resp_rdata", resp_rdata, m_rdata);
        check("resp_error", resp_error, m_err);
        $display("resp edge=%0d rdata=%h err=%0d", edge_n, resp_rdata, resp_error);
      end
    end
  end

  task automatic wait_resp(input bit sel, output int lat, output logic [31:0] rd, output logic er);
    bit got;
    got = 0; lat = 0; rd = '0; er = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (sel ? rv0 : resp_valid) begin
        got = 1;
        rd  = sel ? rd0 : resp_rdata;
        er  = sel ? re0 : resp_error;
      end else begin
        lat++;
      end
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input bit sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er);
    bit got;
    got = 0; lat = 0; rd = '0; er = 1'b0;
    @(posedge clk); #1;
    if (sel) begin en0 = 1; v0 = 1; w0 = wr; a0 = addr; d0 = wd; end
    else begin enable = 1; req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (sel ? rdy0 : req_ready) got = 1;
    end
    @(posedge clk); #1;
    // Scramble request inputs right after accept; the in-flight access must not see them.
    if (sel) begin v0 = 0; w0 = ~wr; a0 = $urandom; d0 = $urandom; end
    else begin req_valid = 0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom; end
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    wait_resp(sel, lat, rd, er);
    $display("txn dut%0d wr=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             sel ? 0 : W, wr, addr, wd, rd, er, lat);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 7);
    a = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
    if (r == 6)      a[1:0] = 2'($urandom_range(1, 3));
    else if (r == 7) a = $urandom | 32'h0000_0100;
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int          lat, viol, cnt;
    logic [31:0] rd;
    logic        er;
    bit          got;
    int          resp_at[$];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_error", resp_error, 1'b0);
    check("rst_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;

    for (int i = 0; i < DEPTH; i++) do_req(0, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), lat, rd, er);

    do_req(0, 1'b1, 32'h40, 32'hFF, lat, rd, er);
    check("sw40_rdata", rd, 32'h0);
    check("sw40_err", er, 1'b0);
    check("sw40_lat", lat, 3);
    do_req(0, 1'b0, 32'h40, 32'h0, lat, rd, er);
    check("lw40_rdata", rd, 32'hFF);
    check("lw40_err", er, 1'b0);
    check("lw40_lat", lat, 3);

    do_req(0, 1'b0, 32'h42, 32'h0, lat, rd, er);
    check("lw42_err", er, 1'b1);
    check("lw42_rdata", rd, 32'h0);
    check("lw42_lat", lat, 3);
    do_req(0, 1'b0, 32'h100, 32'h0, lat, rd, er);
    check("lw100_err", er, 1'b1);
    check("lw100_rdata", rd, 32'h0);
    check("lw100_lat", lat, 3);
    do_req(0, 1'b1, 32'h103, 32'hDEAD_BEEF, lat, rd, er);
    check("sw103_err", er, 1'b1);
    do_req(0, 1'b0, 32'h0C, 32'h0, lat, rd, er);
    check("lw0c_unchanged", rd, 32'hA500_0003);
    do_req(0, 1'b0, 32'h40, 32'h0, lat, rd, er);
    check("lw40_unchanged", rd, 32'hFF);

    // Store aborted by reset one edge after its accept.
    @(posedge clk); #1;
    enable = 1; req_valid = 1; req_write = 1; req_addr = 32'h44; req_wdata = 32'h1234;
    @(negedge clk);
    check("abort_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    cnt = 0;
    repeat (8) begin @(negedge clk); if (resp_valid) cnt++; end
    check("abort_no_resp", cnt, 0);
    do_req(0, 1'b0, 32'h44, 32'h0, lat, rd, er);
    check("abort_ram17", rd, 32'hA500_0011);

    // Enable low with a pending request.
    @(posedge clk); #1;
    enable = 0; req_valid = 1; req_write = 0; req_addr = 32'h40;
    viol = 0;
    repeat (10) begin @(negedge clk); if (req_ready || busy || resp_valid) viol++; end
    check("en_low_quiet", viol, 0);
    @(posedge clk); #1;
    enable = 1;
    @(negedge clk);
    check("en_high_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    check("en_high_busy", busy, 1'b1);
    wait_resp(0, lat, rd, er);
    check("en_high_rdata", rd, 32'hFF);
    check("en_high_lat", lat, 2);

    // Back-to-back loads with req_valid held.
    @(posedge clk); #1;
    enable = 1; req_valid = 1; req_write = 0; req_addr = 32'h40;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (resp_valid) resp_at.push_back(c);
    end
    @(posedge clk); #1;
    req_valid = 0;
    repeat (6) @(posedge clk);
    check("b2b_count", resp_at.size(), 6);
    for (int i = 1; i < resp_at.size(); i++) check("b2b_spacing", resp_at[i] - resp_at[i-1], W + 2);

    // Zero-wait instance.
    do_req(1, 1'b1, 32'h40, 32'hFF, lat, rd, er);
    check("w0_sw_lat", lat, 1);
    check("w0_sw_rdata", rd, 32'h0);
    do_req(1, 1'b0, 32'h40, 32'h0, lat, rd, er);
    check("w0_lw_lat", lat, 1);
    check("w0_lw_rdata", rd, 32'hFF);
    check("w0_lw_err", er, 1'b0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        enable = 1'($urandom_range(0, 1));
        req_valid = 0;
      end
      @(posedge clk); #1;
      enable = 1; req_valid = 1; req_write = 1'($urandom_range(0, 1));
      req_addr = rand_addr(); req_wdata = $urandom;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (req_ready) got = 1;
      end
      if (!got) check("rand_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 3) == 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = rand_addr();
      req_wdata = $urandom;
      enable    = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    req_valid = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
